// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared widths, RAM depth and FSM state encoding for the
// ram_master bus master and its address generator.
`default_nettype none

package ram_master_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 3;
  localparam int RAM_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_addr_gen.sv
// ram_addr_gen: burst address register with RAM-depth wrap and a remaining-beat
// down-counter. cur_addr is the address of the next beat to issue.
`default_nettype none

module ram_addr_gen
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last_beat
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    if (load) begin
      // The first beat is issued straight from load_addr, so start one ahead.
      cur_addr_d = wrap_inc(load_addr);
      rem_d      = load_len;
    end else if (advance) begin
      cur_addr_d = wrap_inc(cur_addr_q);
      rem_d      = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q <= '0;
      rem_q      <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
    end
  end

  assign cur_addr  = cur_addr_q;
  assign last_beat = (rem_q == '0);

endmodule

`default_nettype wire

// File: rtl/ram_master.sv
// ram_master: sequences the block RAM's address, write-enable and bus-enable
// pins for single writes and 1-8 beat wrapping read bursts; all outputs registered.
`default_nettype none

module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_iwr,
  output logic              ram_edtb,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_done
);

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_iwr_q, ram_iwr_d;
  logic              ram_edtb_q, ram_edtb_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic              wr_done_q, wr_done_d;

  logic              accept;
  logic              ag_load;
  logic              ag_advance;
  logic [ADDR_W-1:0] ag_cur_addr;
  logic              ag_last_beat;

  assign accept = req_valid && req_ready_q;

  ram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_addr (req_addr),
    .load_len  (req_len),
    .advance   (ag_advance),
    .cur_addr  (ag_cur_addr),
    .last_beat (ag_last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = req_we ? ST_WR : ST_RD;
      ST_RD:   if (ag_last_beat) state_d = ST_IDLE;
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_iwr_d   = 1'b0;
    ram_edtb_d  = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_last_d   = 1'b0;
    wr_done_d   = 1'b0;
    req_ready_d = (state_d == ST_IDLE);
    ag_load     = 1'b0;
    ag_advance  = 1'b0;

    // The bus carries beat data only while we are driving ram_edtb.
    if (ram_edtb_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ram_rdata;
      rd_last_d  = ag_last_beat;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_wdata_d = req_wdata;
            ram_iwr_d   = 1'b1;
          end else begin
            ram_edtb_d = 1'b1;
            ag_load    = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (!ag_last_beat) begin
          ram_addr_d = ag_cur_addr;
          ram_edtb_d = 1'b1;
          ag_advance = 1'b1;
        end
      end
      ST_WR: wr_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_iwr_q   <= 1'b0;
      ram_edtb_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_iwr_q   <= ram_iwr_d;
      ram_edtb_q  <= ram_edtb_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_iwr   = ram_iwr_q;
  assign ram_edtb  = ram_edtb_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign wr_done   = wr_done_q;

endmodule

`default_nettype wire
